// File: rtl/avalon_dmem_master_if.sv
// Avalon-MM bus bundle between the data-memory master and the interconnect.
interface avalon_dmem_master_if;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    output avm_write,
    output avm_writedata,
    output avm_byteenable,
    input  avm_readdata,
    input  avm_waitrequest,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    input  avm_write,
    input  avm_writedata,
    input  avm_byteenable,
    output avm_readdata,
    output avm_waitrequest,
    output avm_readdatavalid
  );
endinterface

// File: rtl/avalon_dmem_master.sv
// Avalon-MM master for the core's data-memory port: one single-word read or
// write per held request, a one-cycle done_ext pulse on completion, and a
// per-wait-state timeout that aborts the transaction and sets a sticky err.
module avalon_dmem_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] daddr,
  input  logic [31:0] ddata_w,
  input  logic        WRam,
  input  logic        RRam,
  output logic [31:0] ddata_r,
  output logic        done_ext,
  output logic        err,
  avalon_dmem_master_if.master avm
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    RD_REQ,
    RD_WAIT,
    DONE,
    RELEASE
  } state_t;

  // Counter value during the last allowed cycle of a wait state.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_is_read;

  // Word alignment discards the byte offset.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^daddr[1:0];

  // Transaction FSM; every output is a register set on state transitions.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state            <= IDLE;
      r_cnt              <= '0;
      r_is_read          <= 1'b0;
      ddata_r            <= '0;
      done_ext           <= 1'b0;
      err                <= 1'b0;
      avm.avm_address    <= '0;
      avm.avm_read       <= 1'b0;
      avm.avm_write      <= 1'b0;
      avm.avm_writedata  <= '0;
      avm.avm_byteenable <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (WRam) begin
            avm.avm_address    <= {daddr[31:2], 2'b00};
            avm.avm_writedata  <= ddata_w;
            avm.avm_write      <= 1'b1;
            avm.avm_byteenable <= '1;
            r_cnt              <= '0;
            r_is_read          <= 1'b0;
            r_state            <= WR_REQ;
          end else if (RRam) begin
            avm.avm_address    <= {daddr[31:2], 2'b00};
            avm.avm_read       <= 1'b1;
            avm.avm_byteenable <= '1;
            r_cnt              <= '0;
            r_is_read          <= 1'b1;
            r_state            <= RD_REQ;
          end
        end

        WR_REQ: begin
          if (!avm.avm_waitrequest) begin
            avm.avm_write      <= 1'b0;
            avm.avm_byteenable <= '0;
            done_ext           <= 1'b1;
            r_state            <= DONE;
          end else if (r_cnt == TO_LAST) begin
            avm.avm_write      <= 1'b0;
            avm.avm_byteenable <= '0;
            err                <= 1'b1;
            done_ext           <= 1'b1;
            r_state            <= DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        RD_REQ: begin
          if (!avm.avm_waitrequest) begin
            avm.avm_read       <= 1'b0;
            avm.avm_byteenable <= '0;
            if (avm.avm_readdatavalid) begin
              ddata_r  <= avm.avm_readdata;
              done_ext <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_cnt   <= '0;
              r_state <= RD_WAIT;
            end
          end else if (r_cnt == TO_LAST) begin
            avm.avm_read       <= 1'b0;
            avm.avm_byteenable <= '0;
            err                <= 1'b1;
            ddata_r            <= ERR_DATA;
            done_ext           <= 1'b1;
            r_state            <= DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        RD_WAIT: begin
          if (avm.avm_readdatavalid) begin
            ddata_r  <= avm.avm_readdata;
            done_ext <= 1'b1;
            r_state  <= DONE;
          end else if (r_cnt == TO_LAST) begin
            err      <= 1'b1;
            ddata_r  <= ERR_DATA;
            done_ext <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        DONE: begin
          done_ext <= 1'b0;
          r_state  <= RELEASE;
        end

        // Only the served request must drop; the other one is re-sampled in IDLE.
        RELEASE: begin
          if (r_is_read ? !RRam : !WRam) begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
